// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared opcode, state and control-select encodings for the
//               CPU controller.
// Revision    : 1.0
// ============================================================================
package cpu_pkg;

  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_TRAP   = 3'd7
  } state_t;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_FUNC = 2'b01;
  localparam logic [1:0] ALU_CMP  = 2'b10;

  typedef struct packed {
    logic is_lui;
    logic is_auipc;
    logic is_jal;
    logic is_jalr;
    logic is_branch;
    logic is_load;
    logic is_store;
    logic is_op_imm;
    logic is_op;
    logic is_system;
    logic writes_rd;
    logic is_legal;
  } ctrl_class_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_class_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_class_decode
// Description : Maps the 5-bit opcode onto instruction-class flags.
// Revision    : 1.0
// ============================================================================
module ctrl_class_decode
  import cpu_pkg::*;
(
  input  logic [4:0]  opcode,
  output ctrl_class_t cls
);

  always_comb begin
    cls           = '0;
    cls.is_lui    = (opcode == OPC_LUI);
    cls.is_auipc  = (opcode == OPC_AUIPC);
    cls.is_jal    = (opcode == OPC_JAL);
    cls.is_jalr   = (opcode == OPC_JALR);
    cls.is_branch = (opcode == OPC_BRANCH);
    cls.is_load   = (opcode == OPC_LOAD);
    cls.is_store  = (opcode == OPC_STORE);
    cls.is_op_imm = (opcode == OPC_OP_IMM);
    cls.is_op     = (opcode == OPC_OP);
    cls.is_system = (opcode == OPC_SYSTEM);
    cls.writes_rd = cls.is_lui | cls.is_auipc | cls.is_jal | cls.is_jalr |
                    cls.is_load | cls.is_op | cls.is_op_imm;
    // SYSTEM is handled separately by the FSM and is not part of this set
    cls.is_legal  = cls.writes_rd | cls.is_branch | cls.is_store;
  end

endmodule
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// Module      : cpu_controller
// Description : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory
//               handshakes, datapath selects and retired-instruction count.
// Revision    : 1.0
// ============================================================================
module cpu_controller
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  opcode,
  input  logic [2:0]  func3,
  input  logic        func7,
  input  logic [4:0]  rd_index,
  input  logic        br_taken,
  input  logic        im_ready,
  input  logic        dm_ready,
  output logic        im_req,
  output logic        ir_we,
  output logic        opd_we,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  alu_op_sel,
  output logic        dm_req,
  output logic        dm_we,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] instret
);

  ctrl_class_t w_cls;
  state_t      r_state;
  logic        r_br_q;
  logic [31:0] r_instret;
  logic        w_alu_active;
  logic        w_unused_func;

  // func3/func7 are consumed by the ALU itself; the sequencer ignores them
  assign w_unused_func = ^{func3, func7};

  ctrl_class_decode u_class_decode (
    .opcode (opcode),
    .cls    (w_cls)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_instret <= '0;
      r_br_q    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE:   r_state <= ST_FETCH;
        ST_FETCH:  if (im_ready) r_state <= ST_DECODE;
        ST_DECODE: begin
          if (w_cls.is_system)     r_state <= ST_HALT;
          else if (!w_cls.is_legal) r_state <= ST_TRAP;
          else                     r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (w_cls.is_load || w_cls.is_store) begin
            r_state <= ST_MEM;
          end else begin
            r_state <= ST_WB;
            r_br_q  <= br_taken;
          end
        end
        ST_MEM:    if (dm_ready) r_state <= ST_WB;
        ST_WB: begin
          r_instret <= r_instret + 32'd1;
          r_state   <= ST_FETCH;
        end
        ST_HALT:   r_state <= ST_HALT;
        ST_TRAP:   r_state <= ST_TRAP;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // ALU select stays stable from EXEC through WB so addresses/results hold
  assign w_alu_active = (r_state == ST_EXEC) || (r_state == ST_MEM) ||
                        (r_state == ST_WB);

  always_comb begin
    im_req     = 1'b0;
    ir_we      = 1'b0;
    opd_we     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 1'b0;
    alu_op_sel = ALU_ADD;
    dm_req     = 1'b0;
    dm_we      = 1'b0;
    reg_we     = 1'b0;
    wb_sel     = WB_ALU;
    pc_we      = 1'b0;
    pc_sel     = PC_PLUS4;
    halted     = 1'b0;
    illegal    = 1'b0;

    if (w_alu_active) begin
      if (w_cls.is_op) begin
        alu_op_sel = ALU_FUNC;
      end else if (w_cls.is_op_imm) begin
        alu_src_b  = 1'b1;
        alu_op_sel = ALU_FUNC;
      end else if (w_cls.is_load || w_cls.is_store || w_cls.is_jalr) begin
        alu_src_b  = 1'b1;
      end else if (w_cls.is_auipc) begin
        alu_src_a  = 1'b1;
        alu_src_b  = 1'b1;
      end else if (w_cls.is_branch) begin
        alu_op_sel = ALU_CMP;
      end
    end

    case (r_state)
      ST_FETCH: begin
        im_req = 1'b1;
        ir_we  = im_ready;
      end
      ST_DECODE: opd_we = 1'b1;
      ST_MEM: begin
        dm_req = 1'b1;
        dm_we  = w_cls.is_store;
      end
      ST_WB: begin
        pc_we  = 1'b1;
        reg_we = w_cls.writes_rd && (rd_index != 5'd0);
        if (w_cls.is_lui)                        wb_sel = WB_IMM;
        else if (w_cls.is_jal || w_cls.is_jalr)  wb_sel = WB_PC4;
        else if (w_cls.is_load)                  wb_sel = WB_MEM;
        if (w_cls.is_jal)                        pc_sel = PC_IMM;
        else if (w_cls.is_jalr)                  pc_sel = PC_ALU;
        else if (w_cls.is_branch && r_br_q)      pc_sel = PC_IMM;
      end
      ST_HALT:   halted  = 1'b1;
      ST_TRAP:   illegal = 1'b1;
      default: ;
    endcase
  end

  assign instret = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_controller
// Description : Directed self-checking bench for cpu_controller.
// Revision    : 1.0
// ============================================================================
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  opcode;
  logic [2:0]  func3;
  logic        func7;
  logic [4:0]  rd_index;
  logic        br_taken;
  logic        im_ready;
  logic        dm_ready;
  logic        im_req, ir_we, opd_we, alu_src_a, alu_src_b;
  logic [1:0]  alu_op_sel;
  logic        dm_req, dm_we, reg_we;
  logic [1:0]  wb_sel;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        halted, illegal;
  logic [31:0] instret;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cpu_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .func3      (func3),
    .func7      (func7),
    .rd_index   (rd_index),
    .br_taken   (br_taken),
    .im_ready   (im_ready),
    .dm_ready   (dm_ready),
    .im_req     (im_req),
    .ir_we      (ir_we),
    .opd_we     (opd_we),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op_sel (alu_op_sel),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .reg_we     (reg_we),
    .wb_sel     (wb_sel),
    .pc_we      (pc_we),
    .pc_sel     (pc_sel),
    .halted     (halted),
    .illegal    (illegal),
    .instret    (instret)
  );

  // {im_req,ir_we,opd_we,a,b,alu_op_sel,dm_req,dm_we,reg_we,wb_sel,pc_we,pc_sel,halted,illegal}
  wire [16:0] outs = {im_req, ir_we, opd_we, alu_src_a, alu_src_b, alu_op_sel,
                      dm_req, dm_we, reg_we, wb_sel, pc_we, pc_sel, halted, illegal};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Steps until WB (pc_we) is seen; returns cycles taken, 20 on timeout.
  task automatic cycles_to_wb(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!pc_we && n < 20);
  endtask

  task automatic test_reset();
    opcode = 5'b01100; rd_index = 5'd5; im_ready = 1'b1; dm_ready = 1'b1;
    rst_n = 1'b0;
    step();
    vectors++;
    if (outs !== 17'h0 || instret !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: outs=%h instret=%0d required outs=0 instret=0", outs, instret);
    end
    rst_n = 1'b1;
    step();
    vectors++;
    if (im_req !== 1'b1 || ir_we !== 1'b1 || opd_we !== 1'b0) begin
      miscompares++;
      $display("FAIL first_fetch: im_req=%b ir_we=%b opd_we=%b required 1 1 0", im_req, ir_we, opd_we);
    end
  endtask

  task automatic test_add();
    int n;
    do_reset();
    opcode = 5'b01100; rd_index = 5'd5; im_ready = 1'b1; dm_ready = 1'b1;
    step();
    step();
    vectors++;
    if (opd_we !== 1'b1 || im_req !== 1'b0) begin
      miscompares++;
      $display("FAIL add_decode: opd_we=%b im_req=%b required 1 0", opd_we, im_req);
    end
    step();
    vectors++;
    if (alu_op_sel !== 2'b01 || alu_src_a !== 1'b0 || alu_src_b !== 1'b0) begin
      miscompares++;
      $display("FAIL add_exec_alu: sel=%b a=%b b=%b required 01 0 0", alu_op_sel, alu_src_a, alu_src_b);
    end
    step();
    vectors++;
    if (pc_we !== 1'b1 || reg_we !== 1'b1 || wb_sel !== 2'b00 || pc_sel !== 2'b00 || instret !== 32'd0) begin
      miscompares++;
      $display("FAIL add_wb: pc_we=%b reg_we=%b wb_sel=%b pc_sel=%b instret=%0d required 1 1 00 00 0",
               pc_we, reg_we, wb_sel, pc_sel, instret);
    end
    step();
    vectors++;
    if (instret !== 32'd1 || im_req !== 1'b1) begin
      miscompares++;
      $display("FAIL add_retire: instret=%0d im_req=%b required 1 1", instret, im_req);
    end
    cycles_to_wb(n);
    vectors++;
    if (n !== 3) begin
      miscompares++;
      $display("FAIL add_latency_from_fetch: cycles=%0d required 3", n);
    end
  endtask

  task automatic test_load_stall();
    int cnt;
    int total;
    do_reset();
    opcode = 5'b00000; rd_index = 5'd3; im_ready = 1'b1; dm_ready = 1'b0;
    step(); step(); step();
    total = 3;
    vectors++;
    if (alu_src_b !== 1'b1 || alu_op_sel !== 2'b00 || dm_req !== 1'b0) begin
      miscompares++;
      $display("FAIL load_exec: b=%b sel=%b dm_req=%b required 1 00 0", alu_src_b, alu_op_sel, dm_req);
    end
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (!dm_req) break;
      cnt++;
      vectors++;
      if (dm_we !== 1'b0 || alu_src_b !== 1'b1) begin
        miscompares++;
        $display("FAIL load_mem_hold: dm_we=%b b=%b required 0 1", dm_we, alu_src_b);
      end
      if (cnt == 4) dm_ready = 1'b1;
    end
    vectors++;
    if (cnt !== 4 || total !== 8) begin
      miscompares++;
      $display("FAIL load_stall_len: dm_req_cycles=%0d total=%0d required 4 8", cnt, total);
    end
    vectors++;
    if (pc_we !== 1'b1 || wb_sel !== 2'b01 || reg_we !== 1'b1) begin
      miscompares++;
      $display("FAIL load_wb: pc_we=%b wb_sel=%b reg_we=%b required 1 01 1", pc_we, wb_sel, reg_we);
    end
  endtask

  task automatic test_store();
    int n;
    do_reset();
    opcode = 5'b01000; rd_index = 5'd9; im_ready = 1'b1; dm_ready = 1'b1;
    step(); step(); step(); step();
    vectors++;
    if (dm_req !== 1'b1 || dm_we !== 1'b1) begin
      miscompares++;
      $display("FAIL store_mem: dm_req=%b dm_we=%b required 1 1", dm_req, dm_we);
    end
    step();
    vectors++;
    if (pc_we !== 1'b1 || reg_we !== 1'b0) begin
      miscompares++;
      $display("FAIL store_wb: pc_we=%b reg_we=%b required 1 0", pc_we, reg_we);
    end
    cycles_to_wb(n);
    vectors++;
    if (n !== 5) begin
      miscompares++;
      $display("FAIL store_latency: cycles=%0d required 5", n);
    end
  endtask

  task automatic test_branch();
    do_reset();
    opcode = 5'b11000; rd_index = 5'd4; im_ready = 1'b1; dm_ready = 1'b1; br_taken = 1'b0;
    step(); step(); step();
    vectors++;
    if (alu_op_sel !== 2'b10) begin
      miscompares++;
      $display("FAIL branch_exec_sel: sel=%b required 10", alu_op_sel);
    end
    br_taken = 1'b1;
    step();
    vectors++;
    if (pc_sel !== 2'b01 || reg_we !== 1'b0 || pc_we !== 1'b1) begin
      miscompares++;
      $display("FAIL branch_taken_wb: pc_sel=%b reg_we=%b pc_we=%b required 01 0 1", pc_sel, reg_we, pc_we);
    end
    step(); step();
    step();
    br_taken = 1'b0;
    step();
    br_taken = 1'b1;
    vectors++;
    if (pc_sel !== 2'b00 || reg_we !== 1'b0 || pc_we !== 1'b1 || instret !== 32'd1) begin
      miscompares++;
      $display("FAIL branch_not_taken_wb: pc_sel=%b reg_we=%b pc_we=%b instret=%0d required 00 0 1 1",
               pc_sel, reg_we, pc_we, instret);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] t_opc [6];
    logic [4:0] t_rd  [6];
    logic [7:0] t_exp [6]; // {reg_we, wb_sel, pc_sel, a, b, unused} packed below
    logic [1:0] t_alu [6];
    int n;
    t_opc = '{5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b01100, 5'b00100};
    t_rd  = '{5'd2, 5'd3, 5'd1, 5'd1, 5'd0, 5'd7};
    t_exp = '{8'b1_11_00_0_0_0, 8'b1_00_00_1_1_0, 8'b1_10_01_0_0_0,
              8'b1_10_10_0_1_0, 8'b0_00_00_0_0_0, 8'b1_00_00_0_1_0};
    t_alu = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
    do_reset();
    im_ready = 1'b1; dm_ready = 1'b1; br_taken = 1'b0;
    for (int i = 0; i < 6; i++) begin
      opcode = t_opc[i]; rd_index = t_rd[i];
      cycles_to_wb(n);
      vectors++;
      if (n !== 4 || {reg_we, wb_sel, pc_sel, alu_src_a, alu_src_b, 1'b0} !== t_exp[i] ||
          alu_op_sel !== t_alu[i] || pc_we !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_wb[%0d]: cycles=%0d got=%b alu=%b pc_we=%b required 4 %b %b 1",
                 i, n, {reg_we, wb_sel, pc_sel, alu_src_a, alu_src_b, 1'b0}, alu_op_sel, pc_we,
                 t_exp[i], t_alu[i]);
      end
    end
    step();
    vectors++;
    if (instret !== 32'd6) begin
      miscompares++;
      $display("FAIL b2b_instret: instret=%0d required 6", instret);
    end
  endtask

  task automatic test_trap_halt();
    do_reset();
    opcode = 5'b11111; rd_index = 5'd1; im_ready = 1'b1; dm_ready = 1'b1;
    step(); step(); step();
    step(); step();
    vectors++;
    if (outs !== 17'h00001 || instret !== 32'd0) begin
      miscompares++;
      $display("FAIL trap_sticky: outs=%h instret=%0d required 00001 0", outs, instret);
    end
    do_reset();
    vectors++;
    if (illegal !== 1'b0 || outs !== 17'h0) begin
      miscompares++;
      $display("FAIL trap_reset_clear: outs=%h required 0", outs);
    end
    opcode = 5'b11100;
    step(); step(); step();
    step(); step();
    vectors++;
    if (outs !== 17'h00002 || instret !== 32'd0) begin
      miscompares++;
      $display("FAIL halt_sticky: outs=%h instret=%0d required 00002 0", outs, instret);
    end
    do_reset();
    vectors++;
    if (halted !== 1'b0 || outs !== 17'h0) begin
      miscompares++;
      $display("FAIL halt_reset_clear: outs=%h required 0", outs);
    end
  endtask

  task automatic test_reset_mid_mem();
    int n;
    do_reset();
    opcode = 5'b01100; rd_index = 5'd5; im_ready = 1'b1; dm_ready = 1'b1;
    cycles_to_wb(n);
    opcode = 5'b00000; dm_ready = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!dm_req && n < 20);
    vectors++;
    if (dm_req !== 1'b1 || instret !== 32'd1) begin
      miscompares++;
      $display("FAIL midmem_reach: dm_req=%b instret=%0d required 1 1", dm_req, instret);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; dm_ready = 1'b1;
    vectors++;
    if (outs !== 17'h0 || instret !== 32'd0) begin
      miscompares++;
      $display("FAIL midmem_reset: outs=%h instret=%0d required 0 0", outs, instret);
    end
    step();
    vectors++;
    if (im_req !== 1'b1 || dm_req !== 1'b0) begin
      miscompares++;
      $display("FAIL midmem_resume: im_req=%b dm_req=%b required 1 0", im_req, dm_req);
    end
  endtask

  initial begin
    rst_n = 1'b0; opcode = '0; func3 = '0; func7 = 1'b0; rd_index = '0;
    br_taken = 1'b0; im_ready = 1'b0; dm_ready = 1'b0;
    test_reset();
    test_add();
    test_load_stall();
    test_store();
    test_branch();
    test_back_to_back();
    test_trap_halt();
    test_reset_mid_mem();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
